// File: rtl/bpsk_tx_ctrl_pkg.sv
// Shared types and defaults for the BPSK transmit path.
// Also used by the modulator and the receiver.
package bpsk_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } state_e;

  localparam int unsigned LEN_W = 8;

  localparam logic [8:0] DEF_PREAMBLE_WORD = 9'h155;
  localparam logic [8:0] DEF_FILL_WORD     = 9'h1FF;

endpackage

// File: rtl/bpsk_symbol_timer.sv
// Sample counter for one modulator word period.
// Strobes on the last sample of each word while enabled.
module bpsk_symbol_timer
  import bpsk_tx_ctrl_pkg::*;
#(
  parameter int unsigned W = 2304
) (
  input  logic clk,
  input  logic arst,
  input  logic en,
  output logic word_strobe
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign word_strobe = en && (cnt_q == CW'(W - 1));

  always_comb begin
    cnt_d = '0;
    if (en && !word_strobe) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bpsk_tx_ctrl.sv
// Frame sequencer feeding the BPSK modulator:
// preamble words, then parity-tagged payload words.
module bpsk_tx_ctrl
  import bpsk_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned SAMPLES_PER_SYM = 256,
  parameter int unsigned PREAMBLE_LEN    = 4,
  parameter logic [DATA_WIDTH:0] PREAMBLE_WORD = DEF_PREAMBLE_WORD,
  parameter logic [DATA_WIDTH:0] FILL_WORD     = DEF_FILL_WORD
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_W-1:0]      frame_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mod_en,
  output logic [DATA_WIDTH:0]   mod_in,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
);

  localparam int unsigned W  = (DATA_WIDTH + 1) * SAMPLES_PER_SYM;
  localparam int unsigned PW = $clog2(PREAMBLE_LEN + 1);

  state_e                state_q, state_d;
  logic                  mod_en_q, mod_en_d;
  logic [DATA_WIDTH:0]   mod_in_q, mod_in_d;
  logic                  done_q, done_d;
  logic                  undr_q, undr_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  full_q, full_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [LEN_W-1:0]      sent_q, sent_d;
  logic [LEN_W-1:0]      acc_q, acc_d;
  logic [LEN_W-1:0]      len_q, len_d;

  logic                  strobe;
  logic                  accept;
  logic                  load;
  logic [PW-1:0]         pre_nx;
  logic [DATA_WIDTH:0]   load_word;

  bpsk_symbol_timer #(
    .W(W)
  ) u_timer (
    .clk        (clk),
    .arst       (arst),
    .en         (mod_en_q),
    .word_strobe(strobe)
  );

  assign s_ready = (state_q == ST_PRE || state_q == ST_DATA)
                && !full_q && (acc_q < len_q);
  assign accept  = s_valid && s_ready;
  assign pre_nx  = pre_q + PW'(1);

  // MSB is even parity over the payload; empty buffer sends fill
  assign load_word = full_q ? {^buf_q, buf_q} : FILL_WORD;

  always_comb begin
    state_d  = state_q;
    mod_en_d = mod_en_q;
    mod_in_d = mod_in_q;
    done_d   = 1'b0;
    undr_d   = undr_q;
    buf_d    = buf_q;
    full_d   = full_q;
    pre_d    = pre_q;
    sent_d   = sent_q;
    acc_d    = acc_q;
    len_d    = len_q;
    load     = 1'b0;

    if (accept) begin
      buf_d  = s_data;
      full_d = 1'b1;
      acc_d  = acc_q + LEN_W'(1);
    end

    if (abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      mod_en_d = 1'b0;
      mod_in_d = '0;
      full_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && frame_len != '0) begin
            state_d  = ST_PRE;
            mod_en_d = 1'b1;
            mod_in_d = PREAMBLE_WORD;
            undr_d   = 1'b0;
            len_d    = frame_len;
            pre_d    = '0;
            sent_d   = '0;
            acc_d    = '0;
            full_d   = 1'b0;
          end
        end
        ST_PRE: begin
          if (strobe) begin
            pre_d = pre_nx;
            if (pre_nx == PW'(PREAMBLE_LEN)) begin
              load    = 1'b1;
              state_d = (len_q == LEN_W'(1)) ? ST_TAIL : ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (strobe) begin
            load = 1'b1;
            if (sent_q + LEN_W'(1) == len_q) state_d = ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (strobe) begin
            state_d  = ST_IDLE;
            mod_en_d = 1'b0;
            mod_in_d = '0;
            done_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A full buffer blocks accept, so emptying it here never races
    if (load) begin
      mod_in_d = load_word;
      sent_d   = sent_q + LEN_W'(1);
      if (full_q) full_d = 1'b0;
      else        undr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_IDLE;
      mod_en_q <= 1'b0;
      mod_in_q <= '0;
      done_q   <= 1'b0;
      undr_q   <= 1'b0;
      buf_q    <= '0;
      full_q   <= 1'b0;
      pre_q    <= '0;
      sent_q   <= '0;
      acc_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      mod_en_q <= mod_en_d;
      mod_in_q <= mod_in_d;
      done_q   <= done_d;
      undr_q   <= undr_d;
      buf_q    <= buf_d;
      full_q   <= full_d;
      pre_q    <= pre_d;
      sent_q   <= sent_d;
      acc_q    <= acc_d;
      len_q    <= len_d;
    end
  end

  assign mod_en   = mod_en_q;
  assign mod_in   = mod_in_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign underrun = undr_q;

endmodule

// File: tb/tb_bpsk_tx_ctrl.sv
// Scoreboard bench for bpsk_tx_ctrl with a frame-level model.
// Word period is 36 clocks (SAMPLES_PER_SYM = 4).
module tb_bpsk_tx_ctrl;

  localparam int WP  = 36;
  localparam int PRE = 4;

  logic       clk = 1'b0;
  logic       arst;
  logic       start;
  logic       abort;
  logic [7:0] frame_len;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       mod_en;
  logic [8:0] mod_in;
  logic       busy;
  logic       done;
  logic       underrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] src[$];
  logic [8:0] exp_w[$];
  int         exp_len[$];
  bit         exp_done[$];
  bit         exp_ur[$];
  bit         skip = 1'b0;
  int         acc_cnt = 0;

  bpsk_tx_ctrl #(
    .DATA_WIDTH     (8),
    .SAMPLES_PER_SYM(4),
    .PREAMBLE_LEN   (PRE),
    .PREAMBLE_WORD  (9'h155),
    .FILL_WORD      (9'h1FF)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .start    (start),
    .abort    (abort),
    .frame_len(frame_len),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .mod_en   (mod_en),
    .mod_in   (mod_in),
    .busy     (busy),
    .done     (done),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] with_parity(logic [7:0] b);
    return {1'($countones(b) % 2), b};
  endfunction

  // byte source: presents the queue head, pops on handshake
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(posedge clk);
      if (s_valid && s_ready && !arst) begin
        src.delete(0);
        acc_cnt++;
      end
      #1;
      if (src.size() > 0) begin
        s_valid = 1'b1;
        s_data  = src[0];
      end else begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
      end
    end
  end

  // monitor: one word sample per period, run checks at mod_en fall
  int k = 0;
  bit prev = 1'b0;
  always @(negedge clk) begin
    if (skip || arst) begin
      k    = 0;
      prev = 1'b0;
    end else begin
      if (mod_en) begin
        if (k % WP == 0) begin
          if (exp_w.size() == 0) check("word_queue_empty", 1, 0);
          else check("mod_in", 32'(mod_in), 32'(exp_w.pop_front()));
        end
        k++;
      end else if (prev) begin
        if (exp_len.size() == 0) begin
          check("run_queue_empty", 1, 0);
        end else begin
          check("mod_en_cycles", k, exp_len.pop_front());
          check("done_pulse", 32'(done), 32'(exp_done.pop_front()));
          check("underrun", 32'(underrun), 32'(exp_ur.pop_front()));
        end
        k = 0;
      end else if (done) begin
        check("spurious_done", 32'(done), 0);
      end
      prev = mod_en;
    end
  end

  task automatic run_frame(input int len, input bit mid_start);
    int n;
    int c;
    int lim;
    n = src.size();
    for (int i = 0; i < PRE; i++) exp_w.push_back(9'h155);
    for (int i = 0; i < len; i++)
      exp_w.push_back(i < n ? with_parity(src[i]) : 9'h1FF);
    exp_len.push_back((PRE + len) * WP);
    exp_done.push_back(1'b1);
    exp_ur.push_back(n < len);
    repeat (2) @(posedge clk);
    #1;
    acc_cnt   = 0;
    start     = 1'b1;
    frame_len = 8'(len);
    @(posedge clk);
    #1;
    start     = 1'b0;
    frame_len = 8'($urandom_range(0, 255));
    check("busy_after_start", 32'(busy), 1);
    check("underrun_cleared", 32'(underrun), 0);
    lim = (PRE + len) * WP + 20;
    c = 0;
    while (c < lim && busy) begin
      if (mid_start && c == 40) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      c++;
    end
    if (busy) check("frame_timeout", 1, 0);
    check("bytes_accepted", acc_cnt, (n < len) ? n : len);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen_ready;
    arst      = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    frame_len = '0;
    #3;
    check("rst_mod_en", 32'(mod_en), 0);
    check("rst_mod_in", 32'(mod_in), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_done", 32'(done), 0);
    check("rst_underrun", 32'(underrun), 0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;

    // normal frame with pre-supplied bytes
    src.push_back(8'hA5);
    src.push_back(8'h3C);
    run_frame(2, 1'b0);

    // parity bit set
    src.push_back(8'h01);
    run_frame(1, 1'b0);

    // underrun, then next start clears it; start while busy ignored
    src.push_back(8'h5A);
    run_frame(3, 1'b0);
    src.push_back(8'h77);
    src.push_back(8'h88);
    src.push_back(8'h99);
    run_frame(3, 1'b1);

    // backpressure: 5 offered, 2 taken, rest waits
    for (int i = 0; i < 5; i++) src.push_back(8'($urandom));
    run_frame(2, 1'b0);
    check("bytes_left_waiting", src.size(), 3);
    run_frame(3, 1'b0);

    // start with zero length stays idle
    src.push_back(8'hC3);
    repeat (2) @(posedge clk);
    #1;
    start     = 1'b1;
    frame_len = 8'd0;
    @(posedge clk);
    #1 start  = 1'b0;
    check("zero_len_busy", 32'(busy), 0);
    check("zero_len_mod_en", 32'(mod_en), 0);
    check("zero_len_s_ready", 32'(s_ready), 0);
    src.delete();

    // abort at cycle 50 of a 4-word frame
    src.push_back(8'h11);
    src.push_back(8'h22);
    exp_w.push_back(9'h155);
    exp_w.push_back(9'h155);
    exp_len.push_back(51);
    exp_done.push_back(1'b0);
    exp_ur.push_back(1'b0);
    repeat (2) @(posedge clk);
    #1;
    acc_cnt   = 0;
    start     = 1'b1;
    frame_len = 8'd4;
    @(posedge clk);
    #1 start  = 1'b0;
    repeat (50) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_mod_en", 32'(mod_en), 0);
    check("abort_mod_in", 32'(mod_in), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    seen_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (s_ready) seen_ready = 1'b1;
    end
    check("abort_no_ready", 32'(seen_ready), 0);
    check("abort_accepted", acc_cnt, 1);
    // the byte taken before abort is lost
    run_frame(2, 1'b0);

    // async reset mid-frame
    skip = 1'b1;
    src.push_back(8'hE7);
    src.push_back(8'h42);
    repeat (2) @(posedge clk);
    #1;
    start     = 1'b1;
    frame_len = 8'd3;
    @(posedge clk);
    #1 start  = 1'b0;
    repeat (100) @(posedge clk);
    #2 arst = 1'b1;
    #1;
    check("arst_mod_en", 32'(mod_en), 0);
    check("arst_mod_in", 32'(mod_in), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_s_ready", 32'(s_ready), 0);
    check("arst_done", 32'(done), 0);
    @(posedge clk);
    #1 arst = 1'b0;
    exp_w.delete();
    exp_len.delete();
    exp_done.delete();
    exp_ur.delete();
    src.delete();
    @(posedge clk);
    #1;
    check("post_arst_done", 32'(done), 0);
    check("post_arst_busy", 32'(busy), 0);
    skip = 1'b0;

    // randomized frames against the model
    for (int f = 0; f < 6; f++) begin
      int len;
      int nb;
      len = $urandom_range(1, 6);
      nb  = $urandom_range(0, 8);
      for (int i = 0; i < nb; i++) src.push_back(8'($urandom));
      run_frame(len, 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    check("words_drained", exp_w.size(), 0);
    check("runs_drained", exp_len.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
